mult_iter: RTL and testbench
============================

# mult_iter

Parametrised iterative integer multiplier for the EX stage, the next generation of the single-width MUL/MULH unit. MUL returns the low WIDTH bits of the product in the same cycle. MULH, MULHSU and MULHU compute the high WIDTH bits over WIDTH/CHUNK iteration cycles, which lets area be traded against latency. It follows the existing EX-stage handshake: enable_i starts an operation, ready_o stalls the pipeline, and ex_ready_i releases the result.

## Interface
- WIDTH, default 32: operand and result width.
- CHUNK, default 16: bits of op_b consumed per iteration. WIDTH % CHUNK must be 0. N = WIDTH/CHUNK, with N ≥ 1.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- enable_i  in  1  operation request; sampled only in IDLE.
- operator_i  in  3  mul_opcode_e: MUL_MAC32 = 3'b000, MUL_H = 3'b110. Any other code is unsupported.
- short_signed_i  in  2  bit 0 set = op_a signed; bit 1 set = op_b signed. 11 = mulh, 01 = mulhsu, 00 = mulhu. Ignored for MUL_MAC32.
- op_a_i, op_b_i  in  WIDTH  operands.
- ex_ready_i  in  1  EX stage accepts the result.
- result_o  out  WIDTH  product result.
- ready_o  out  1  result valid / unit free. Low stalls the pipeline.
- mulh_active_o  out  1  a high-part operation is in flight.

## Operation
- FSM states: IDLE, ITER, FINISH. Reset state is IDLE with the accumulator and counter cleared.
- **IDLE**
  - enable_i=1 and MUL_MAC32: result_o = low WIDTH bits of op_a_i*op_b_i, combinational. ready_o=1. No state change.
  - enable_i=1 and MUL_H:
    - Latch op_a_i, op_b_i and short_signed_i.
    - Clear the accumulator and set count=0.
    - Go to ITER.
    - ready_o=0 in this cycle (combinational).
  - enable_i=0, or an unsupported operator: result_o=0, ready_o=1, no state change.
- **ITER**
  - Each cycle, add the contribution of op_b chunk [count], bits count*CHUNK+CHUNK-1 : count*CHUNK, to the accumulator.
  - Only the top chunk carries op_b's sign, and only when short_signed_i[1]=1.
  - op_a is sign-extended when short_signed_i[0]=1.
  - count increments each cycle. When count==N-1, go to FINISH.
  - ready_o=0 and result_o=0 throughout.
- **FINISH**
  - result_o = bits [2W-1:W] of the exact 2W-bit product of the latched operands, under the latched signedness. ready_o=1.
  - ex_ready_i=1: go to IDLE. ex_ready_i=0: stay in FINISH and hold result_o.
- Accumulator width: at least 2W+2 bits signed. There must be no overflow for any operand/sign combination.
- Internal datapath is free, provided the results and cycle counts above hold exactly.

## Timing
- Reset values: ready_o=1, result_o=0, mulh_active_o=0. Reset takes effect immediately and asynchronously.
- MUL latency: 0 cycles. ready_o is never low for MUL.
- MULH latency, with the accept cycle as cycle 0:
  - ready_o is low in cycles 0..N.
  - The result is valid with ready_o=1 in cycle N+1.
  - Default N=2: 3 stall cycles, result in the 4th cycle.
- mulh_active_o is high in ITER and FINISH and low in IDLE.
- Inputs outside the IDLE accept cycle are ignored:
  - Changes to op_a_i, op_b_i, short_signed_i, operator_i or enable_i during ITER or FINISH have no effect.
  - There is no abort.
- Back-to-back: FINISH with ex_ready_i=1 in cycle k means a new MUL or MULH can be accepted in cycle k+1. enable_i during FINISH never starts a new operation.
- Reset during ITER or FINISH: return to IDLE, discard the partial result and clear the accumulator. The next request executes normally.

## Test plan
- MUL, a=0x0000_0007, b=0xFFFF_FFFD -> result_o=0xFFFF_FFEB and ready_o=1 in the same cycle; mulh_active_o stays 0.
- MULH (11), a=b=0x8000_0000 -> ready_o low for 3 cycles, then result_o=0x4000_0000 with ready_o=1.
- MULHU (00), a=b=0xFFFF_FFFF -> 0xFFFF_FFFE. MULHSU (01), a=b=0xFFFF_FFFF -> 0xFFFF_FFFF. MULH (11), a=b=0xFFFF_FFFF -> 0x0000_0000.
- FINISH with ex_ready_i=0 for 5 cycles, while op_a_i/op_b_i toggle and enable_i is held high -> result_o is stable with ready_o=1 throughout. Exactly one operation completes, and the next is accepted only after ex_ready_i=1.
- rst_n pulsed low during ITER -> ready_o=1, result_o=0 and mulh_active_o=0 immediately. A following MULH (11), 0x0001_0000 × 0x0001_0000 -> 0x0000_0001.
- Parameter sweep WIDTH=32 with CHUNK ∈ {8, 16, 32}, and WIDTH=16 with CHUNK=4:
  - ready_o is low exactly N+1 cycles for MULH.
  - 10k random operands across all four modes match a reference model.
  - Unsupported opcodes give ready_o=1, result_o=0.

Source files
------------

// File: rtl/mult_iter_if.sv
// rtl/mult_iter_if.sv - EX-stage request/result bundle for mult_iter
// master = EX stage issuing operations, slave = the multiplier.
interface mult_iter_if #(
  parameter int WIDTH = 32
);
  logic             enable_i;
  logic [2:0]       operator_i;
  logic [1:0]       short_signed_i;
  logic [WIDTH-1:0] op_a_i;
  logic [WIDTH-1:0] op_b_i;
  logic             ex_ready_i;
  logic [WIDTH-1:0] result_o;
  logic             ready_o;
  logic             mulh_active_o;

  modport master (
    output enable_i, operator_i, short_signed_i, op_a_i, op_b_i, ex_ready_i,
    input  result_o, ready_o, mulh_active_o
  );

  modport slave (
    input  enable_i, operator_i, short_signed_i, op_a_i, op_b_i, ex_ready_i,
    output result_o, ready_o, mulh_active_o
  );
endinterface

// File: rtl/mult_iter.sv
// rtl/mult_iter.sv - iterative integer multiplier: 0-cycle MUL low, chunked MULH/MULHSU/MULHU
// High part is built by accumulating op_a * op_b[chunk] over WIDTH/CHUNK cycles.
module mult_iter #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 16
) (
  input logic        clk,
  input logic        rst_n,
  mult_iter_if.slave bus
);

  localparam logic [2:0] MUL_MAC32 = 3'b000;
  localparam logic [2:0] MUL_H     = 3'b110;

  localparam int N     = WIDTH / CHUNK;
  localparam int CW    = (N > 1) ? $clog2(N) : 1;
  localparam int PW    = WIDTH + CHUNK + 2;
  localparam int ACC_W = 2 * WIDTH + 2;

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    FINISH
  } state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0]        a_q, b_q;
  logic [1:0]              sign_q;
  logic signed [ACC_W-1:0] acc_q;
  logic [CW-1:0]           count_q;

  logic                    accept;
  logic                    last_chunk;
  logic [CHUNK-1:0]        b_chunk;
  logic signed [WIDTH:0]   a_ext;
  logic signed [CHUNK:0]   b_ext;
  logic signed [PW-1:0]    partial;
  logic signed [ACC_W-1:0] contrib;
  logic [WIDTH-1:0]        mul_lo;

  assign mul_lo     = bus.op_a_i * bus.op_b_i;
  assign last_chunk = (count_q == CW'(N - 1));
  assign b_chunk    = CHUNK'(b_q >> (int'(count_q) * CHUNK));

  // Only the most significant chunk of op_b may carry a sign; lower chunks are magnitudes.
  assign a_ext   = {sign_q[0] & a_q[WIDTH-1], a_q};
  assign b_ext   = {sign_q[1] & last_chunk & b_chunk[CHUNK-1], b_chunk};
  assign partial = PW'(a_ext) * PW'(b_ext);
  assign contrib = ACC_W'(partial) <<< (int'(count_q) * CHUNK);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    accept       = 1'b0;
    bus.ready_o  = 1'b1;
    bus.result_o = '0;
    case (state_q)
      IDLE: begin
        if (bus.enable_i) begin
          if (bus.operator_i == MUL_MAC32) begin
            bus.result_o = mul_lo;
          end else if (bus.operator_i == MUL_H) begin
            accept      = 1'b1;
            bus.ready_o = 1'b0;
            state_d     = ITER;
          end
        end
      end
      ITER: begin
        bus.ready_o = 1'b0;
        if (last_chunk) begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        bus.result_o = acc_q[2*WIDTH-1:WIDTH];
        if (bus.ex_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.mulh_active_o = (state_q != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sign_q  <= '0;
      acc_q   <= '0;
      count_q <= '0;
    end else if (accept) begin
      a_q     <= bus.op_a_i;
      b_q     <= bus.op_b_i;
      sign_q  <= bus.short_signed_i;
      acc_q   <= '0;
      count_q <= '0;
    end else if (state_q == ITER) begin
      acc_q   <= acc_q + contrib;
      count_q <= count_q + CW'(1);
    end
  end

endmodule

// File: tb/tb_mult_iter.sv
// tb/tb_mult_iter.sv - directed and randomized checks of mult_iter against an arithmetic model
module tb_mult_iter;

  localparam logic [2:0] MUL_MAC32 = 3'b000;
  localparam logic [2:0] MUL_H     = 3'b110;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic m_rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Exact high half of the 2w-bit product, from signed/unsigned integer values.
  function automatic logic [63:0] ref_mulh(input logic [63:0] a, input logic [63:0] b,
                                           input logic [1:0] ss, input int w);
    logic signed [129:0] sa, sb, p;
    sa = {66'd0, a};
    sb = {66'd0, b};
    if (ss[0] && a[w-1]) sa = sa - (130'sd1 <<< w);
    if (ss[1] && b[w-1]) sb = sb - (130'sd1 <<< w);
    p = sa * sb;
    return 64'(p >>> w) & ((64'd1 << w) - 64'd1);
  endfunction

  mult_iter_if #(.WIDTH(32)) m_if();
  mult_iter #(.WIDTH(32), .CHUNK(16)) u_main (.clk(clk), .rst_n(m_rst_n), .bus(m_if));

  task automatic drive(input logic en, input logic [2:0] op, input logic [1:0] ss,
                       input logic [31:0] a, input logic [31:0] b, input logic exr);
    m_if.enable_i       = en;
    m_if.operator_i     = op;
    m_if.short_signed_i = ss;
    m_if.op_a_i         = a;
    m_if.op_b_i         = b;
    m_if.ex_ready_i     = exr;
  endtask

  // Called at the negedge of the accept cycle; returns at the negedge where ready_o rises.
  task automatic wait_result(output int stalls);
    stalls = 1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      m_if.enable_i = 1'b0;
      @(negedge clk);
      if (m_if.ready_o) break;
      stalls++;
    end
  endtask

  task automatic run_mulh(input string tag, input logic [1:0] ss, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
    int stalls;
    drive(1'b1, MUL_H, ss, a, b, 1'b1);
    @(negedge clk);
    check({tag, "_accept_ready"}, 64'(m_if.ready_o), 64'd0);
    wait_result(stalls);
    check({tag, "_stalls"}, 64'(stalls), 64'd3);
    check({tag, "_result"}, 64'(m_if.result_o), 64'(exp));
    check({tag, "_active"}, 64'(m_if.mulh_active_o), 64'd1);
    @(posedge clk); #1;
    m_if.enable_i = 1'b0;
  endtask

  for (genvar g = 0; g < 4; g++) begin : g_sweep
    localparam int W = (g == 3) ? 16 : 32;
    localparam int C = (g == 0) ? 16 : (g == 1) ? 8 : (g == 2) ? 32 : 4;
    localparam int N = W / C;

    bit done_g = 1'b0;

    mult_iter_if #(.WIDTH(W)) s_if();
    mult_iter #(.WIDTH(W), .CHUNK(C)) u_dut (.clk(clk), .rst_n(rst_n), .bus(s_if));

    initial begin
      logic [W-1:0] a, b;
      logic [2:0]   op;
      logic [63:0]  exp, mask;
      int           mode, stalls;
      mask = (64'd1 << W) - 64'd1;
      s_if.enable_i       = 1'b0;
      s_if.operator_i     = MUL_MAC32;
      s_if.short_signed_i = 2'b00;
      s_if.op_a_i         = '0;
      s_if.op_b_i         = '0;
      s_if.ex_ready_i     = 1'b1;
      wait (rst_n === 1'b1);
      @(posedge clk); #1;
      for (int i = 0; i < 2500; i++) begin
        a    = W'($urandom);
        b    = W'($urandom);
        mode = $urandom_range(0, 5);
        s_if.op_a_i         = a;
        s_if.op_b_i         = b;
        s_if.enable_i       = 1'b1;
        s_if.ex_ready_i     = 1'b1;
        s_if.short_signed_i = 2'($urandom);
        if (mode == 0) begin
          s_if.operator_i = MUL_MAC32;
          exp = (64'(a) * 64'(b)) & mask;
        end else if (mode == 5) begin
          do op = 3'($urandom); while (op == MUL_MAC32 || op == MUL_H);
          s_if.operator_i = op;
          exp = 64'd0;
        end else begin
          s_if.operator_i     = MUL_H;
          s_if.short_signed_i = 2'(mode - 1);
          exp = ref_mulh(64'(a), 64'(b), 2'(mode - 1), W);
        end
        @(negedge clk);
        if (mode == 0 || mode == 5) begin
          check($sformatf("sweep%0d_single_ready", g), 64'(s_if.ready_o), 64'd1);
          check($sformatf("sweep%0d_single_result", g), 64'(s_if.result_o), exp);
          check($sformatf("sweep%0d_single_active", g), 64'(s_if.mulh_active_o), 64'd0);
        end else begin
          check($sformatf("sweep%0d_accept_ready", g), 64'(s_if.ready_o), 64'd0);
          stalls = 1;
          for (int k = 0; k < N + 8; k++) begin
            @(posedge clk); #1;
            s_if.enable_i       = 1'($urandom);
            s_if.operator_i     = 3'($urandom);
            s_if.short_signed_i = 2'($urandom);
            s_if.op_a_i         = W'($urandom);
            s_if.op_b_i         = W'($urandom);
            @(negedge clk);
            if (s_if.ready_o) break;
            stalls++;
          end
          check($sformatf("sweep%0d_stalls", g), 64'(stalls), 64'(N + 1));
          check($sformatf("sweep%0d_mulh_result", g), 64'(s_if.result_o), exp);
          check($sformatf("sweep%0d_finish_active", g), 64'(s_if.mulh_active_o), 64'd1);
        end
        @(posedge clk); #1;
      end
      s_if.enable_i = 1'b0;
      done_g = 1'b1;
    end
  end

  initial begin
    logic [2:0]  bad_ops [6];
    logic [31:0] exp_hold, exp_next;
    int          stalls;
    bit          all_done;
    bad_ops = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd7};
    drive(1'b0, MUL_MAC32, 2'b00, 32'd0, 32'd0, 1'b1);
    #1;
    check("reset_ready", 64'(m_if.ready_o), 64'd1);
    check("reset_result", 64'(m_if.result_o), 64'd0);
    check("reset_active", 64'(m_if.mulh_active_o), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n   = 1'b1;
    m_rst_n = 1'b1;
    @(posedge clk); #1;

    drive(1'b1, MUL_MAC32, 2'b11, 32'h0000_0007, 32'hFFFF_FFFD, 1'b1);
    @(negedge clk);
    check("mul_result", 64'(m_if.result_o), 64'hFFFF_FFEB);
    check("mul_ready", 64'(m_if.ready_o), 64'd1);
    check("mul_active", 64'(m_if.mulh_active_o), 64'd0);
    @(posedge clk); #1;
    drive(1'b0, MUL_MAC32, 2'b00, 32'd0, 32'd0, 1'b1);
    @(negedge clk);
    check("mul_after_active", 64'(m_if.mulh_active_o), 64'd0);
    @(posedge clk); #1;

    run_mulh("mulh_min", 2'b11, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    run_mulh("mulhu_ones", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_mulh("mulhsu_ones", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_mulh("mulh_ones", 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);

    // Result held in FINISH while inputs churn and enable_i stays high.
    exp_hold = 32'(ref_mulh(64'h1234_5678, 64'h9ABC_DEF0, 2'b11, 32));
    drive(1'b1, MUL_H, 2'b11, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
    @(negedge clk);
    check("hold_accept_ready", 64'(m_if.ready_o), 64'd0);
    wait_result(stalls);
    check("hold_stalls", 64'(stalls), 64'd3);
    check("hold_result", 64'(m_if.result_o), 64'(exp_hold));
    for (int j = 0; j < 5; j++) begin
      @(posedge clk); #1;
      drive(1'b1, MUL_H, 2'($urandom), $urandom, $urandom, 1'b0);
      @(negedge clk);
      check($sformatf("hold%0d_ready", j), 64'(m_if.ready_o), 64'd1);
      check($sformatf("hold%0d_result", j), 64'(m_if.result_o), 64'(exp_hold));
      check($sformatf("hold%0d_active", j), 64'(m_if.mulh_active_o), 64'd1);
    end
    exp_next = 32'(ref_mulh(64'hFFFF_0000, 64'h0003_0001, 2'b11, 32));
    @(posedge clk); #1;
    drive(1'b1, MUL_H, 2'b11, 32'hFFFF_0000, 32'h0003_0001, 1'b1);
    @(negedge clk);
    check("release_result", 64'(m_if.result_o), 64'(exp_hold));
    check("release_ready", 64'(m_if.ready_o), 64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("b2b_accept_ready", 64'(m_if.ready_o), 64'd0);
    check("b2b_accept_active", 64'(m_if.mulh_active_o), 64'd0);
    wait_result(stalls);
    check("b2b_stalls", 64'(stalls), 64'd3);
    check("b2b_result", 64'(m_if.result_o), 64'(exp_next));
    @(posedge clk); #1;
    m_if.enable_i = 1'b0;

    // Asynchronous reset in the middle of ITER.
    drive(1'b1, MUL_H, 2'b11, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1);
    @(posedge clk); #1;
    m_if.enable_i = 1'b0;
    #2 m_rst_n = 1'b0;
    #1;
    check("rst_iter_ready", 64'(m_if.ready_o), 64'd1);
    check("rst_iter_result", 64'(m_if.result_o), 64'd0);
    check("rst_iter_active", 64'(m_if.mulh_active_o), 64'd0);
    @(negedge clk);
    m_rst_n = 1'b1;
    @(posedge clk); #1;
    run_mulh("post_rst", 2'b11, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001);

    foreach (bad_ops[i]) begin
      drive(1'b1, bad_ops[i], 2'($urandom), $urandom, $urandom, 1'b1);
      @(negedge clk);
      check($sformatf("bad_op%0d_ready", bad_ops[i]), 64'(m_if.ready_o), 64'd1);
      check($sformatf("bad_op%0d_result", bad_ops[i]), 64'(m_if.result_o), 64'd0);
      @(posedge clk); #1;
    end
    m_if.enable_i = 1'b0;

    all_done = 1'b0;
    for (int t = 0; t < 60000; t++) begin
      all_done = g_sweep[0].done_g && g_sweep[1].done_g && g_sweep[2].done_g && g_sweep[3].done_g;
      if (all_done) break;
      @(posedge clk);
    end
    check("sweep_done", 64'(all_done), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
